// File: rtl/queue_fifo.sv
// queue_fifo: single-clock FIFO with registered pop data and registered
// empty/full flags. Buffers request/response words between pipeline stages.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active low
//   rd_en   pop request (ignored when empty)
//   wr_en   push request (ignored when full unless popping the same cycle)
//   buf_in  push data
//   buf_out registered pop data, holds when no pop occurs
//   empty   occupancy == 0 (registered)
//   full    occupancy == QUEUE_SIZE (registered)
module queue_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int QUEUE_SIZE     = 8,
  parameter int QUEUE_SIZE_BIT = 3,
  parameter int COUNTER_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] buf_in,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0]     mem_q [QUEUE_SIZE];
  logic [QUEUE_SIZE_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [QUEUE_SIZE_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [COUNTER_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0]     buf_out_q;
  logic                      empty_q, full_q;
  logic                      do_wr, do_rd;

  // A full queue still accepts a push when a pop frees a slot this cycle.
  // A pop on an empty queue never falls through to the incoming word.
  assign do_rd = rd_en && !empty_q;
  assign do_wr = wr_en && (!full_q || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointer width equals log2(QUEUE_SIZE), so increments wrap for free.
    if (do_wr) wr_ptr_d = wr_ptr_q + QUEUE_SIZE_BIT'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + QUEUE_SIZE_BIT'(1);
    if (do_wr && !do_rd)      count_d = count_q + COUNTER_WIDTH'(1);
    else if (do_rd && !do_wr) count_d = count_q - COUNTER_WIDTH'(1);
  end

  // Storage carries no reset; stale contents are unreachable via pointers.
  always_ff @(posedge clk) begin
    if (do_wr && rst) mem_q[wr_ptr_q] <= buf_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      buf_out_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_rd) buf_out_q <= mem_q[rd_ptr_q];
      // Flags come from the next count so they line up with the new state.
      empty_q <= (count_d == '0);
      full_q  <= (count_d == COUNTER_WIDTH'(QUEUE_SIZE));
    end
  end

  assign buf_out = buf_out_q;
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: tb/tb_queue_fifo.sv
// Directed + randomized bench for queue_fifo against a queue-based model.
module tb_queue_fifo;
  localparam int DW = 32;
  localparam int QS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] buf_in = '0;
  logic [DW-1:0] buf_out;
  logic          empty, full;

  queue_fifo #(.DATA_WIDTH(DW), .QUEUE_SIZE(QS), .QUEUE_SIZE_BIT(3), .COUNTER_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .buf_in(buf_in), .buf_out(buf_out), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a plain queue, last popped word.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_out;
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".buf_out"}, buf_out, m_out);
    chk({tag, ".empty"}, {31'd0, empty}, {31'd0, mq.size() == 0});
    chk({tag, ".full"},  {31'd0, full},  {31'd0, mq.size() == QS});
  endtask

  // One clock with given request; model updated from the behavioural rules.
  task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    bit m_full, m_empty;
    @(negedge clk);
    wr_en = w; rd_en = r; buf_in = d; rst = 1'b1;
    m_full  = (mq.size() == QS);
    m_empty = (mq.size() == 0);
    if (r && !m_empty) m_out = mq.pop_front();
    if (w && (!m_full || r)) mq.push_back(d);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic w, input logic r);
    @(negedge clk);
    rst = 1'b0; wr_en = w; rd_en = r; buf_in = 32'hDEAD_BEEF;
    mq.delete(); m_out = '0;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    // Reset, with requests asserted to show reset wins.
    do_reset("reset", 1'b1, 1'b1);

    // Empty-queue simultaneous ops: read ignored, then real pop.
    step("empty_wr_rd", 1, 1, 32'd10);
    step("wr_rd_one",   1, 1, 32'd20);

    // Fill and overflow.
    for (int i = 3; i <= 9; i++) step("fill", 1, 0, DW'(i * 10));
    step("overflow", 1, 0, 32'd100);
    for (int i = 0; i < QS; i++) step("drain", 0, 1, '0);

    // Full simultaneous push/pop.
    for (int i = 0; i < QS; i++) step("fill2", 1, 0, DW'(110 + i));
    step("full_wr_rd", 1, 1, 32'd140);
    for (int i = 0; i < QS; i++) step("drain2", 0, 1, '0);

    // Underflow, then single word round trip.
    step("underflow", 0, 1, 32'd77);
    step("push5", 1, 0, 32'd5);
    step("pop5",  0, 1, '0);

    // Two more full fill/drain cycles so both pointers wrap.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < QS; i++) step("wrap_fill", 1, 0, $urandom);
      for (int i = 0; i < QS; i++) step("wrap_drain", 0, 1, '0);
    end

    // Reset mid-operation discards entries; following pop ignored.
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, DW'(200 + i));
    do_reset("mid_reset", 1'b0, 1'b1);
    step("pop_after_rst", 0, 1, '0);

    // Randomized traffic with drifting bias so both full and empty are hit.
    for (int i = 0; i < 400; i++) begin
      int wp = ((i / 50) % 2 == 0) ? 75 : 30;
      step("rand", ($urandom_range(99) < wp), ($urandom_range(99) < 100 - wp), $urandom);
      if (i == 250) do_reset("rand_reset", 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
